// File: rtl/priority_interrupt_controller.sv
// Priority interrupt controller with edge-triggered sources, a mask register,
// nesting against the in-service set and a registered request/ack handshake.
//
// Ports:
//   clk        - sole clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   irq_in     - raw interrupt lines, bit NUM_IRQ-1 has the highest priority
//   mask_wr    - load mask_data into the mask register this cycle
//   mask_data  - new mask value, 1 = source masked
//   irq_req    - registered interrupt request to the CPU
//   irq_id     - registered ID of the requested source
//   irq_ack    - CPU accepts the current request (ignored while irq_req=0)
//   eoi        - end-of-interrupt strobe
//   eoi_id     - source retired by eoi
//   pending    - pending register
//   in_service - in-service register
//   mask       - current mask register
module priority_interrupt_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               eoi,
    input  logic [ID_W-1:0]    eoi_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] mask
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] mask_q;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] cand_set;
    logic [ID_W-1:0]    cand_idx;
    logic [ID_W-1:0]    isr_idx;
    logic               cand_valid;
    logic               cur_valid;
    logic               ack_take;

    assign rise     = irq_in & ~irq_prev_q;
    assign cand_set = pending_q & ~mask_q;

    // Highest-indexed set bit of the candidate set and of the in-service set.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        cand_idx = '0;
        isr_idx  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand_set[i])     cand_idx = ID_W'(i);
            if (in_service_q[i]) isr_idx  = ID_W'(i);
        end
    end

    // A source may only interrupt if it outranks everything in service.
    assign cand_valid = (|cand_set) && ((in_service_q == '0) || (cand_idx > isr_idx));
    assign cur_valid  = cand_set[irq_id_q] && ((in_service_q == '0) || (irq_id_q > isr_idx));

    // Next-state logic. The held irq_id is never replaced while requesting;
    // a request that loses eligibility is withdrawn and re-arbitrated in IDLE.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cand_valid) begin
                    state_d  = S_REQ;
                    irq_id_d = cand_idx;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    ack_take = 1'b1;
                    state_d  = S_IDLE;
                end else if (!cur_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ordering encodes the same-bit collision rules: a fresh edge re-sets a
    // pending bit cleared by ack, and an ack re-sets an in-service bit cleared
    // by a simultaneous eoi.
    always_comb begin
        pending_d = pending_q;
        if (ack_take) pending_d[irq_id_q] = 1'b0;
        pending_d = pending_d | rise;

        in_service_d = in_service_q;
        if (eoi && (int'(eoi_id) < NUM_IRQ)) in_service_d[eoi_id] = 1'b0;
        if (ack_take) in_service_d[irq_id_q] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            irq_id_q     <= '0;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= '1;
        end else begin
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
            irq_prev_q   <= irq_in;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            if (mask_wr) mask_q <= mask_data;
        end
    end

    assign irq_req    = (state_q == S_REQ);
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;

endmodule

// File: doc/priority_interrupt_controller.md
PRIORITY_INTERRUPT_CONTROLLER -- requirements
Module: priority_interrupt_controller

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 8, giving the number of interrupt sources; legal values are 2..32.
REQ-002 The block SHALL have parameter ID_W, default $clog2(NUM_IRQ), giving the width of interrupt IDs.
REQ-003 The block SHALL have these ports, and SHALL use one clock with a synchronous, active-high reset:
  clk  input  1  sole clock; all state updates on its rising edge
  rst  input  1  synchronous active-high reset
  irq_in  input  NUM_IRQ  raw interrupt lines; bit NUM_IRQ-1 is highest priority
  mask_wr  input  1  load mask_data into the mask register this cycle
  mask_data  input  NUM_IRQ  new mask; 1 = source masked
  irq_req  output  1  interrupt request to CPU, registered
  irq_id  output  ID_W  ID of the requested source, registered
  irq_ack  input  1  CPU accepts the request; valid only while irq_req=1
  eoi  input  1  end-of-interrupt strobe
  eoi_id  input  ID_W  source being retired by eoi
  pending  output  NUM_IRQ  pending register, registered
  in_service  output  NUM_IRQ  in-service register, registered
  mask  output  NUM_IRQ  current mask register

Function
REQ-004 A rising edge SHALL be detected on irq_in[i] when irq_in[i]=1 at a clock edge and was 0 at the previous edge; pending[i] SHALL be set at that same edge.
REQ-005 The candidate set SHALL be pending & ~mask. The candidate SHALL be the highest-indexed bit of that set, and only if its index exceeds the highest set in_service index (or in_service is 0), so that interrupts nest.
REQ-006 The FSM SHALL have two states, IDLE (irq_req=0) and REQ (irq_req=1).
REQ-007 In IDLE with a valid candidate c, the FSM SHALL enter REQ at the next edge with irq_id=c. Latency is edge-detect edge k, pending at k, irq_req=1 after edge k+1.
REQ-008 In REQ, irq_id SHALL stay stable until ack; a higher-priority arrival SHALL NOT replace it.
REQ-009 In REQ, if irq_ack=1, then at that edge pending[irq_id] SHALL be cleared, in_service[irq_id] SHALL be set, and the FSM SHALL return to IDLE. irq_req SHALL stay low for at least one cycle after each ack.
REQ-010 In REQ with no ack, if the current irq_id stops being a valid candidate (masked, or preempted by in_service), the FSM SHALL withdraw by returning to IDLE.
REQ-011 irq_ack while in IDLE SHALL be ignored.
REQ-012 On eoi=1, in_service[eoi_id] SHALL be cleared. An eoi to a bit that is not in service, or with eoi_id>=NUM_IRQ, SHALL have no effect.
REQ-013 Simultaneous events on one bit: a new rising edge together with the ack of that bit SHALL leave pending set (the edge wins). eoi and ack of the same ID in one cycle SHALL leave in_service set (the ack wins).
REQ-014 A mask_wr SHALL take effect at that edge; candidate evaluation SHALL use the updated mask from the next cycle onward.
REQ-015 Masking SHALL NOT clear pending; unmasking a pending source SHALL make it a candidate.
REQ-016 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-017 While rst=1 at an edge, the block SHALL set pending=0, in_service=0, mask=all ones, the edge-detect history to 0, irq_req=0, irq_id=0, and state=IDLE. All other inputs SHALL be ignored.
REQ-018 Reset in the middle of a handshake SHALL abandon that handshake; an irq_ack in the reset cycle SHALL have no effect.
REQ-019 A source held high through reset release SHALL register an edge at the first non-reset edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - Basic: mask=0; pulse irq_in[3] -> pending=0x08, irq_req=1 and irq_id=3 one cycle later; ack -> pending=0, in_service=0x08, irq_req=0.
  - Priority: irq_in[2] and irq_in[6] rise together -> irq_id=6; after ack, irq_req stays 0 (2<6 in service); eoi_id=6 -> irq_id=2 requested.
  - Nesting: in_service=0x04; irq_in[5] rises -> irq_id=5 requested; ack -> in_service=0x24.
  - Mask/withdraw: irq_id=4 requested; mask_wr with 0x10 -> irq_req=0 and pending[4] stays 1; unmask -> irq_id=4 requested again.
  - Collision: irq_in[1] re-rises in its ack cycle -> pending[1]=1, in_service[1]=1.
  - Reset: assert rst while irq_req=1 together with irq_ack -> all registers at their reset values and mask=0xFF.
